mips_ctrl_fsm: RTL and testbench



---
 rtl/mips_ctrl_pkg.sv | 61 ++++++
 rtl/mips_ins_decode.sv | 58 +++++
 rtl/mips_ctrl_fsm.sv | 211 +++++++++++++++++++++
 tb/tb_mips_ctrl_fsm.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared types and constants for the multi-cycle MIPS control unit.
//   state_e      : FSM state encoding (BOOT=0 .. WB=5), also exported on the debug port
//   class_e      : instruction class captured in DECODE
//   OPC_* / FN_* : primary opcode and R-type funct field values that are supported
//   ALU_*        : 3-bit ALU operation codes driven on op
//   funct_decode : funct -> {known, alu op}
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CL_R    = 3'd0,
    CL_LW   = 3'd1,
    CL_SW   = 3'd2,
    CL_BEQ  = 3'd3,
    CL_ADDI = 3'd4,
    CL_J    = 3'd5,
    CL_ILL  = 3'd6
  } class_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2b;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Returns {known, op}; an unknown funct reports known=0 with op=add.
  function automatic logic [3:0] funct_decode(input logic [5:0] funct);
    logic [3:0] r;
    case (funct)
      FN_ADD:  r = {1'b1, ALU_ADD};
      FN_SUB:  r = {1'b1, ALU_SUB};
      FN_AND:  r = {1'b1, ALU_AND};
      FN_OR:   r = {1'b1, ALU_OR};
      FN_SLT:  r = {1'b1, ALU_SLT};
      default: r = {1'b0, ALU_ADD};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_ins_decode.sv
// mips_ins_decode: purely combinational instruction classifier.
//   ins         in  32 : instruction word from yIF
//   cls         out 3  : class_e value (R, LW, SW, BEQ, ADDI, J, ILL)
//   op          out 3  : ALU operation for this instruction
//   illegal_hit out 1  : opcode or R-type funct not supported
// Non-R instructions carry no funct: loads, stores and addi use add for the
// address/immediate sum, beq uses subtract so yEX can raise zero.
module mips_ins_decode
  import mips_ctrl_pkg::*;
(
  input  logic [31:0] ins,
  output logic [2:0]  cls,
  output logic [2:0]  op,
  output logic        illegal_hit
);

  class_e     cls_s;
  logic [3:0] fd_s;
  logic       unused_ins_s;

  // Register/immediate fields are datapath business, not control.
  assign unused_ins_s = ^ins[25:6];

  assign fd_s = funct_decode(ins[5:0]);

  // Classify by opcode, then by funct for R-type.
  always_comb begin
    cls_s = CL_ILL;
    op    = ALU_ADD;
    case (ins[31:26])
      OPC_RTYPE: begin
        if (fd_s[3]) begin
          cls_s = CL_R;
          op    = fd_s[2:0];
        end else begin
          cls_s = CL_ILL;
          op    = ALU_ADD;
        end
      end
      OPC_LW:   cls_s = CL_LW;
      OPC_SW:   cls_s = CL_SW;
      OPC_ADDI: cls_s = CL_ADDI;
      OPC_J:    cls_s = CL_J;
      OPC_BEQ: begin
        cls_s = CL_BEQ;
        op    = ALU_SUB;
      end
      default: begin
        cls_s = CL_ILL;
        op    = ALU_ADD;
      end
    endcase
  end

  assign cls         = cls_s;
  assign illegal_hit = (cls_s == CL_ILL);

endmodule

// File: rtl/mips_ctrl_fsm.sv
// mips_ctrl_fsm: multi-cycle control sequencer for the yIF/yID/yEX/yDM/yWB/yPC datapath.
//   clk, rst (sync, active-high), run (leave FETCH), ins (from yIF), zero (ALU flag, used by yPC)
//   INT, pc_en                    : PC load-entry-point / PC update strobes
//   RegDst, RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite : datapath controls
//   branch, jump                  : yPC next-PC select
//   op                            : ALU operation, captured in DECODE and held
//   illegal                       : sticky unsupported-instruction flag
//   state                         : current FSM state for debug
// Optional build macro CTRL_PERF_CNT_EN adds retired[31:0] and cycles[31:0] counters.
// All outputs are Moore: decoded from the state register and the class/op captured
// in DECODE, so ins has no combinational path to any strobe.
module mips_ctrl_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES = 32'd1
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [31:0] ins,
  input  logic        zero,
  output logic        INT,
  output logic        pc_en,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        Mem2Reg,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        branch,
  output logic        jump,
  output logic [2:0]  op,
  output logic        illegal,
  output logic [2:0]  state
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] retired,
  output logic [31:0] cycles
`endif
);

  localparam int BCW = (BOOT_CYCLES > 32'd1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BCW-1:0] BOOT_LAST = BCW'(BOOT_CYCLES - 32'd1);

  state_e         state_r;
  state_e         state_nxt_s;
  class_e         cls_r;
  logic [2:0]     op_r;
  logic           illegal_r;
  logic [BCW-1:0] boot_cnt_r;

  logic [2:0]     dec_cls_s;
  logic [2:0]     dec_op_s;
  logic           dec_ill_s;
  logic           unused_zero_s;

  // zero steers yPC directly; the sequencer itself never needs it.
  assign unused_zero_s = zero;

  mips_ins_decode u_dec (
    .ins         (ins),
    .cls         (dec_cls_s),
    .op          (dec_op_s),
    .illegal_hit (dec_ill_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_BOOT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Boot timer plus class/op capture at the end of DECODE; illegal is sticky until rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      boot_cnt_r <= '0;
      cls_r      <= CL_ILL;
      op_r       <= ALU_ADD;
      illegal_r  <= 1'b0;
    end else begin
      if (state_r == ST_BOOT) begin
        boot_cnt_r <= boot_cnt_r + BCW'(1);
      end else begin
        boot_cnt_r <= '0;
      end
      if (state_r == ST_DECODE) begin
        cls_r <= class_e'(dec_cls_s);
        op_r  <= dec_op_s;
        if (dec_ill_s) begin
          illegal_r <= 1'b1;
        end
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_BOOT: begin
        if (boot_cnt_r == BOOT_LAST) state_nxt_s = ST_FETCH;
        else                         state_nxt_s = ST_BOOT;
      end
      ST_FETCH: begin
        if (run) state_nxt_s = ST_DECODE;
        else     state_nxt_s = ST_FETCH;
      end
      ST_DECODE: state_nxt_s = ST_EXEC;
      ST_EXEC: begin
        case (cls_r)
          CL_LW, CL_SW:  state_nxt_s = ST_MEM;
          CL_R, CL_ADDI: state_nxt_s = ST_WB;
          default:       state_nxt_s = ST_FETCH;   // BEQ, J, ILL retire here
        endcase
      end
      ST_MEM: begin
        if (cls_r == CL_LW) state_nxt_s = ST_WB;
        else                state_nxt_s = ST_FETCH;
      end
      ST_WB:   state_nxt_s = ST_FETCH;
      default: state_nxt_s = ST_BOOT;
    endcase
  end

  // Moore output decode; every instruction raises pc_en in exactly its last cycle.
  always_comb begin
    INT      = 1'b0;
    pc_en    = 1'b0;
    RegDst   = 1'b0;
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    Mem2Reg  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    op       = op_r;
    illegal  = illegal_r;
    state    = state_r;
    case (state_r)
      ST_BOOT: begin
        INT   = 1'b1;
        pc_en = 1'b1;
      end
      ST_FETCH, ST_DECODE: begin
        pc_en = 1'b0;
      end
      ST_EXEC: begin
        if (cls_r == CL_R || cls_r == CL_BEQ) ALUSrc = 1'b0;
        else                                  ALUSrc = 1'b1;
        case (cls_r)
          CL_BEQ: begin
            branch = 1'b1;
            pc_en  = 1'b1;
          end
          CL_J: begin
            jump  = 1'b1;
            pc_en = 1'b1;
          end
          CL_ILL:  pc_en = 1'b1;              // skip it: PC+4, no writes
          default: pc_en = 1'b0;
        endcase
      end
      ST_MEM: begin
        if (cls_r == CL_LW) begin
          MemRead = 1'b1;
        end else if (cls_r == CL_SW) begin
          MemWrite = 1'b1;
          pc_en    = 1'b1;
        end else begin
          pc_en = 1'b1;                       // unreachable class: still retire once
        end
      end
      ST_WB: begin
        RegWrite = 1'b1;
        pc_en    = 1'b1;
        RegDst   = (cls_r == CL_R);
        Mem2Reg  = (cls_r == CL_LW);
      end
      default: begin
        pc_en = 1'b0;
      end
    endcase
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retired_r;
  logic [31:0] cycles_r;

  // Performance counters: BOOT cycles and the boot PC load are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_r <= 32'd0;
      cycles_r  <= 32'd0;
    end else if (state_r != ST_BOOT) begin
      cycles_r <= cycles_r + 32'd1;
      if (pc_en) begin
        retired_r <= retired_r + 32'd1;
      end
    end
  end

  assign retired = retired_r;
  assign cycles  = cycles_r;
`endif

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
module tb_mips_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst, run, zero;
  logic [31:0] ins;
  logic        INT, pc_en, RegDst, RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite;
  logic        branch, jump, illegal;
  logic [2:0]  op, state;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retired, cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic model_ill = 1'b0;

  mips_ctrl_fsm #(.BOOT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .run(run), .ins(ins), .zero(zero),
    .INT(INT), .pc_en(pc_en), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
    .Mem2Reg(Mem2Reg), .MemRead(MemRead), .MemWrite(MemWrite),
    .branch(branch), .jump(jump), .op(op), .illegal(illegal), .state(state)
`ifdef CTRL_PERF_CNT_EN
    , .retired(retired), .cycles(cycles)
`endif
  );

  always #5 clk = ~clk;

  // Expected per-instruction behaviour: cycle count, state trail (3 bits per
  // cycle, first cycle in the top bits), pulse counts and end-of-instruction values.
  typedef struct packed {
    logic [31:0] ins;
    logic        zero;
    logic [3:0]  cyc;
    logic [14:0] seq;
    logic [1:0]  rw, mw, mr, br, jp, rd, m2r;
    logic        alusrc;
    logic        chk_op;
    logic [2:0]  op;
    logic        ill;
  } vec_t;

  vec_t tbl[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] i, input logic z, input int cyc,
                              input logic [14:0] seq, input int rw, input int mw, input int mr,
                              input int br, input int jp, input int rd, input int m2r,
                              input logic alu, input logic chk, input logic [2:0] o,
                              input logic il);
    vec_t e;
    e.ins = i; e.zero = z; e.cyc = 4'(cyc); e.seq = seq;
    e.rw = 2'(rw); e.mw = 2'(mw); e.mr = 2'(mr); e.br = 2'(br); e.jp = 2'(jp);
    e.rd = 2'(rd); e.m2r = 2'(m2r); e.alusrc = alu; e.chk_op = chk; e.op = o; e.ill = il;
    return e;
  endfunction

  // Reference model built from the instruction-level rules.
  function automatic vec_t model(input logic [31:0] iv, input logic ill_in);
    vec_t e;
    int q[$];
    logic [5:0] o, f;
    logic is_r, is_lw, is_sw, is_beq, is_addi, is_j, is_ill, wr;
    o = iv[31:26];
    f = iv[5:0];
    is_r    = (o == 6'h00) && (f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a});
    is_lw   = (o == 6'h23);
    is_sw   = (o == 6'h2b);
    is_beq  = (o == 6'h04);
    is_addi = (o == 6'h08);
    is_j    = (o == 6'h02);
    is_ill  = !(is_r || is_lw || is_sw || is_beq || is_addi || is_j);
    wr      = is_r || is_addi || is_lw;
    q = {1, 2, 3};
    if (is_lw || is_sw) q.push_back(4);
    if (wr) q.push_back(5);
    e.ins = iv; e.zero = 1'b0;
    e.cyc = 4'(q.size());
    e.seq = 15'd0;
    foreach (q[k]) e.seq[14 - 3*k -: 3] = 3'(q[k]);
    e.rw = {1'b0, wr}; e.mw = {1'b0, is_sw}; e.mr = {1'b0, is_lw};
    e.br = {1'b0, is_beq}; e.jp = {1'b0, is_j}; e.rd = {1'b0, is_r}; e.m2r = {1'b0, is_lw};
    e.alusrc = !(is_r || is_beq);
    e.chk_op = is_r;
    case (f)
      6'h20:   e.op = 3'b010;
      6'h22:   e.op = 3'b110;
      6'h24:   e.op = 3'b000;
      6'h25:   e.op = 3'b001;
      6'h2a:   e.op = 3'b111;
      default: e.op = 3'b010;
    endcase
    e.ill = ill_in || is_ill;
    return e;
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [31:0] r;
    logic [5:0] x;
    logic [5:0] fl[5];
    fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    r = $urandom;
    case ($urandom_range(0, 7))
      0: begin r[31:26] = 6'h00; r[5:0] = fl[$urandom_range(0, 4)]; end
      1: r[31:26] = 6'h23;
      2: r[31:26] = 6'h2b;
      3: r[31:26] = 6'h04;
      4: r[31:26] = 6'h08;
      5: r[31:26] = 6'h02;
      6: begin
        do x = 6'($urandom_range(0, 63));
        while (x inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2b});
        r[31:26] = x;
      end
      default: begin
        do x = 6'($urandom_range(0, 63));
        while (x inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a});
        r[31:26] = 6'h00; r[5:0] = x;
      end
    endcase
    return r;
  endfunction

  // Starts in FETCH; runs one instruction until the FSM is back in FETCH.
  task automatic run_ins(input logic [31:0] iv, input logic zv, input vec_t e, input string tag);
    int n, rw, mw, mr, br, jp, pc, rd, m2r, intc, clash;
    logic alu_x, last_pc;
    logic [2:0] op_last;
    logic [14:0] seq;
    n = 0; rw = 0; mw = 0; mr = 0; br = 0; jp = 0; pc = 0; rd = 0; m2r = 0; intc = 0; clash = 0;
    alu_x = 1'b0; last_pc = 1'b0; op_last = 3'd0; seq = 15'd0;
    ins = iv; zero = zv; run = 1'b1;
    do begin
      if (n < 5) seq[14 - 3*n -: 3] = state;
      rw += int'(RegWrite); mw += int'(MemWrite); mr += int'(MemRead);
      br += int'(branch); jp += int'(jump); pc += int'(pc_en); rd += int'(RegDst);
      m2r += int'(Mem2Reg); intc += int'(INT);
      if (RegWrite && MemWrite) clash++;
      if (state == 3'd3) alu_x = ALUSrc;
      op_last = op;
      last_pc = pc_en;
      n++;
      tick();
    end while (state != 3'd1 && n < 8);
    check({tag, ".cycles"},   32'(n),      32'(e.cyc));
    check({tag, ".states"},   32'(seq),    32'(e.seq));
    check({tag, ".RegWrite"}, 32'(rw),     32'(e.rw));
    check({tag, ".MemWrite"}, 32'(mw),     32'(e.mw));
    check({tag, ".MemRead"},  32'(mr),     32'(e.mr));
    check({tag, ".branch"},   32'(br),     32'(e.br));
    check({tag, ".jump"},     32'(jp),     32'(e.jp));
    check({tag, ".RegDst"},   32'(rd),     32'(e.rd));
    check({tag, ".Mem2Reg"},  32'(m2r),    32'(e.m2r));
    check({tag, ".pc_en"},    32'(pc),     32'd1);
    check({tag, ".pc_last"},  32'(last_pc), 32'd1);
    check({tag, ".INT"},      32'(intc),   32'd0);
    check({tag, ".rw_mw"},    32'(clash),  32'd0);
    check({tag, ".ALUSrc"},   32'(alu_x),  32'(e.alusrc));
    check({tag, ".illegal"},  32'(illegal), 32'(e.ill));
    if (e.chk_op) check({tag, ".op"}, 32'(op_last), 32'(e.op));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    logic [31:0] iv;
    int st;

    tbl[0]  = mk(32'h00221820, 1'b0, 4, {3'd1, 3'd2, 3'd3, 3'd5, 3'd0}, 1, 0, 0, 0, 0, 1, 0, 1'b0, 1'b1, 3'b010, 1'b0);
    tbl[1]  = mk(32'h8C080000, 1'b0, 5, {3'd1, 3'd2, 3'd3, 3'd4, 3'd5}, 1, 0, 1, 0, 0, 0, 1, 1'b1, 1'b0, 3'b010, 1'b0);
    tbl[2]  = mk(32'hAC080004, 1'b0, 4, {3'd1, 3'd2, 3'd3, 3'd4, 3'd0}, 0, 1, 0, 0, 0, 0, 0, 1'b1, 1'b0, 3'b010, 1'b0);
    tbl[3]  = mk(32'h10000003, 1'b1, 3, {3'd1, 3'd2, 3'd3, 3'd0, 3'd0}, 0, 0, 0, 1, 0, 0, 0, 1'b0, 1'b0, 3'b010, 1'b0);
    tbl[4]  = mk(32'h08000020, 1'b0, 3, {3'd1, 3'd2, 3'd3, 3'd0, 3'd0}, 0, 0, 0, 0, 1, 0, 0, 1'b1, 1'b0, 3'b010, 1'b0);
    tbl[5]  = mk(32'h00221822, 1'b0, 4, {3'd1, 3'd2, 3'd3, 3'd5, 3'd0}, 1, 0, 0, 0, 0, 1, 0, 1'b0, 1'b1, 3'b110, 1'b0);
    tbl[6]  = mk(32'h00221824, 1'b0, 4, {3'd1, 3'd2, 3'd3, 3'd5, 3'd0}, 1, 0, 0, 0, 0, 1, 0, 1'b0, 1'b1, 3'b000, 1'b0);
    tbl[7]  = mk(32'h00221825, 1'b0, 4, {3'd1, 3'd2, 3'd3, 3'd5, 3'd0}, 1, 0, 0, 0, 0, 1, 0, 1'b0, 1'b1, 3'b001, 1'b0);
    tbl[8]  = mk(32'h0022182A, 1'b0, 4, {3'd1, 3'd2, 3'd3, 3'd5, 3'd0}, 1, 0, 0, 0, 0, 1, 0, 1'b0, 1'b1, 3'b111, 1'b0);
    tbl[9]  = mk(32'h20010005, 1'b0, 4, {3'd1, 3'd2, 3'd3, 3'd5, 3'd0}, 1, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0, 3'b010, 1'b0);
    tbl[10] = mk(32'hFC000000, 1'b0, 3, {3'd1, 3'd2, 3'd3, 3'd0, 3'd0}, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0, 3'b010, 1'b1);
    tbl[11] = mk(32'h0000003F, 1'b0, 3, {3'd1, 3'd2, 3'd3, 3'd0, 3'd0}, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0, 3'b010, 1'b1);

    // Reset for two cycles, then one BOOT cycle.
    rst = 1'b1; run = 1'b0; ins = 32'd0; zero = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("boot.state", 32'(state), 32'd0);
    check("boot.INT", 32'(INT), 32'd1);
    check("boot.pc_en", 32'(pc_en), 32'd1);
    check("boot.others", 32'({RegDst, RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite, branch, jump}), 32'd0);
    check("boot.op", 32'(op), 32'b010);
    check("boot.illegal", 32'(illegal), 32'd0);
    tick();
    check("boot.to_fetch", 32'(state), 32'd1);
    check("boot.int_off", 32'({INT, pc_en}), 32'd0);

    // run=0 holds FETCH with every strobe low.
    for (int c = 0; c < 20; c++) begin
      tick();
      check("hold.state", 32'(state), 32'd1);
      check("hold.strobes", 32'({INT, pc_en, RegWrite, MemWrite, MemRead, branch, jump}), 32'd0);
    end

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      run_ins(tbl[i].ins, tbl[i].zero, tbl[i], $sformatf("tbl%0d", i));
`ifdef CTRL_PERF_CNT_EN
      if (i == 5) check("perf.retired", retired, 32'd6);
`endif
    end

    // Reset while an lw sits in MEM.
    ins = 32'h8C080000; run = 1'b1;
    tick(); tick(); tick();
    check("rstmem.state", 32'(state), 32'd4);
    check("rstmem.MemRead", 32'(MemRead), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmem.boot", 32'(state), 32'd0);
    check("rstmem.MemRead_off", 32'(MemRead), 32'd0);
    check("rstmem.illegal_clr", 32'(illegal), 32'd0);
    tick();
    check("rstmem.fetch", 32'(state), 32'd1);
    model_ill = 1'b0;

    // Randomized instructions with random FETCH stalls.
    for (int k = 0; k < 150; k++) begin
      iv = rand_ins();
      e = model(iv, model_ill);
      model_ill = e.ill;
      st = $urandom_range(0, 2);
      run = 1'b0;
      for (int s = 0; s < st; s++) begin
        tick();
        check("stall.state", 32'(state), 32'd1);
        check("stall.strobes", 32'({INT, pc_en, RegWrite, MemWrite, MemRead}), 32'd0);
      end
      run_ins(iv, 1'($urandom), e, $sformatf("rnd%0d_%08h", k, iv));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
